simon_stream_ctrl: RTL and testbench

SIMON_STREAM_CTRL -- requirements
Module: simon_stream_ctrl

---
 rtl/simon_pkg.sv | 16 +
 rtl/simon_out_fifo.sv | 45 ++++
 rtl/simon_stream_ctrl.sv | 126 ++++++++++++
 tb/tb_simon_stream_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared types and defaults for the SIMON streaming controller.
package simon_pkg;
  localparam int DEF_N = 24;
  localparam int DEF_M = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY,
    ST_LOAD,
    ST_RUN,
    ST_READ,
    ST_DRAIN
  } state_t;

  typedef logic [2*DEF_N-1:0] block_t;
endpackage

// File: rtl/simon_out_fifo.sv
// Two-entry result buffer holding {mode, block} between the core and the output stream.
module simon_out_fifo #(
  parameter int W = 49
) (
  input  logic         clk,
  input  logic         nR,
  input  logic         push,
  input  logic [W-1:0] wrData,
  input  logic         pop,
  output logic [W-1:0] rdData,
  output logic         notEmpty,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic         wrPtr;
  logic         rdPtr;
  logic         wrEn;
  logic         rdEn;

  // Guards keep the pointers coherent even if a caller misbehaves.
  assign wrEn     = push && (count != 2'd2);
  assign rdEn     = pop && (count != 2'd0);
  assign rdData   = mem[rdPtr];
  assign notEmpty = (count != 2'd0);

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      wrPtr <= 1'b0;
      rdPtr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (wrEn) wrPtr <= ~wrPtr;
      if (rdEn) rdPtr <= ~rdPtr;
      case ({wrEn, rdEn})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr] <= wrData;
  end
endmodule

// File: rtl/simon_stream_ctrl.sv
// Stream front-end for a SIMON block-cipher core: key/block handshakes, core sequencing,
// run timeout and a two-entry result buffer.
module simon_stream_ctrl
  import simon_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int M       = DEF_M,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           nR,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [2*N-1:0] s_data,
  input  logic           s_enc_dec,
  input  logic           k_valid,
  output logic           k_ready,
  input  logic [M*N-1:0] k_data,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [2*N-1:0] m_data,
  output logic           m_enc_dec,
  output logic           newData,
  output logic           newKey,
  output logic           enc_dec,
  output logic           readData,
  output logic [2*N-1:0] blockIN,
  output logic [M*N-1:0] KEY,
  input  logic           loadData,
  input  logic           loadKey,
  input  logic           doneData,
  input  logic [2*N-1:0] outData,
  output logic           busy,
  output logic           err,
  output logic [15:0]    blk_count
);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic [TW-1:0] tmo;
  logic          fifoPush;
  logic          fifoPop;
  logic [1:0]    fifoCount;

  // Key has priority, so s_ready drops while a key is offered to keep the handshake honest.
  assign busy     = (state != ST_IDLE);
  assign k_ready  = (state == ST_IDLE);
  assign s_ready  = (state == ST_IDLE) && (fifoCount != 2'd2) && !k_valid;
  assign fifoPush = (state == ST_READ);
  assign fifoPop  = m_valid && m_ready;

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      state     <= ST_IDLE;
      newData   <= 1'b0;
      newKey    <= 1'b0;
      readData  <= 1'b0;
      enc_dec   <= 1'b1;
      blockIN   <= '0;
      KEY       <= '0;
      err       <= 1'b0;
      tmo       <= '0;
      blk_count <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (k_valid) begin
            KEY    <= k_data;
            newKey <= 1'b1;
            state  <= ST_KEY;
          end else if (s_valid && s_ready) begin
            blockIN <= s_data;
            enc_dec <= s_enc_dec;
            newData <= 1'b1;
            state   <= ST_LOAD;
          end
        end
        ST_KEY: begin
          if (loadKey) begin
            newKey <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (loadData) begin
            newData <= 1'b0;
            tmo     <= '0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (doneData) begin
            readData <= 1'b1;
            state    <= ST_READ;
          end else if (tmo == TW'(TIMEOUT - 1)) begin
            // Core never finished: flag it and drop the block.
            err   <= 1'b1;
            state <= ST_IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        ST_READ: begin
          readData  <= 1'b0;
          blk_count <= blk_count + 16'd1;
          state     <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!doneData) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  simon_out_fifo #(.W(2 * N + 1)) u_fifo (
    .clk      (clk),
    .nR       (nR),
    .push     (fifoPush),
    .wrData   ({enc_dec, outData}),
    .pop      (fifoPop),
    .rdData   ({m_enc_dec, m_data}),
    .notEmpty (m_valid),
    .count    (fifoCount)
  );
endmodule

// File: tb/tb_simon_stream_ctrl.sv
// Bench for simon_stream_ctrl: a SIMON48/96 core model drives the core side, a scoreboard
// predicts every output block from the accepted stream traffic.
module tb_simon_stream_ctrl;
  logic        clk = 1'b0;
  logic        nR = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [47:0] s_data = '0;
  logic        s_enc_dec = 1'b1;
  logic        k_valid = 1'b0;
  logic        k_ready;
  logic [95:0] k_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [47:0] m_data;
  logic        m_enc_dec;
  logic        newData, newKey, enc_dec, readData;
  logic [47:0] blockIN;
  logic [95:0] KEY;
  logic        loadData = 1'b0;
  logic        loadKey = 1'b0;
  logic        doneData = 1'b0;
  logic [47:0] outData = '0;
  logic        busy, err;
  logic [15:0] blk_count;

  simon_stream_ctrl #(.N(24), .M(4), .TIMEOUT(255)) dut (
    .clk(clk), .nR(nR),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_enc_dec(s_enc_dec),
    .k_valid(k_valid), .k_ready(k_ready), .k_data(k_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_enc_dec(m_enc_dec),
    .newData(newData), .newKey(newKey), .enc_dec(enc_dec), .readData(readData),
    .blockIN(blockIN), .KEY(KEY),
    .loadData(loadData), .loadKey(loadKey), .doneData(doneData), .outData(outData),
    .busy(busy), .err(err), .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] rol(input logic [23:0] x, input int r);
    return (x << r) | (x >> (24 - r));
  endfunction

  function automatic logic [23:0] ror(input logic [23:0] x, input int r);
    return (x >> r) | (x << (24 - r));
  endfunction

  function automatic logic [23:0] fr(input logic [23:0] x);
    return (rol(x, 1) & rol(x, 8)) ^ rol(x, 2);
  endfunction

  // SIMON48/96 reference: 36 rounds, constant sequence z1.
  function automatic logic [47:0] simon(input logic [95:0] key, input logic [47:0] blk,
                                        input logic enc);
    logic [23:0] k [36];
    logic [61:0] z;
    logic [23:0] x, y, t;
    z = 62'b10001110111110010011000010110101000111011111001001100001011010;
    for (int i = 0; i < 4; i++) k[i] = key[24*i +: 24];
    for (int i = 4; i < 36; i++) begin
      t = ror(k[i-1], 3) ^ k[i-3];
      t = t ^ ror(t, 1);
      k[i] = k[i-4] ^ t ^ 24'hfffffc ^ {23'd0, z[61-(i-4)]};
    end
    x = blk[47:24];
    y = blk[23:0];
    if (enc) begin
      for (int i = 0; i < 36; i++) begin
        t = x;
        x = y ^ fr(x) ^ k[i];
        y = t;
      end
    end else begin
      for (int i = 35; i >= 0; i--) begin
        t = y;
        y = x ^ fr(y) ^ k[i];
        x = t;
      end
    end
    return {x, y};
  endfunction

  // Scoreboard and core-model state.
  logic [48:0] expQ [$];
  logic [48:0] outLog [$];
  logic [95:0] modelKey = '0;
  logic [47:0] modelBlock = '0;
  logic        modelMode = 1'b1;
  int          delivered = 0;
  int          popped = 0;
  int          accepted = 0;
  bit          discardNext = 0;
  bit          stall = 0;
  bit          prevRead = 0;
  bit          running = 0;
  bit          dropping = 0;
  int          coreLat = 0;
  int          dropWait = 0;
  logic [47:0] coreRes = '0;
  int          readyMode = 0;

  always @(negedge clk) begin
    if (!nR) begin
      loadKey = 1'b0;
      loadData = 1'b0;
      doneData = 1'b0;
      running = 0;
      dropping = 0;
      expQ.delete();
      delivered = 0;
      popped = 0;
      modelKey = '0;
      modelBlock = '0;
      modelMode = 1'b1;
      prevRead = 0;
      discardNext = 0;
    end else begin
      check("m_valid_vs_occupancy", 128'(m_valid), 128'((delivered - popped) != 0));
      if ((delivered - popped) >= 2) check("s_ready_when_full", 128'(s_ready), 128'(0));
      check("blk_count", 128'(blk_count), 128'(16'(delivered)));
      check("KEY_stable", 128'(KEY), 128'(modelKey));
      check("blockIN_stable", 128'(blockIN), 128'(modelBlock));
      check("enc_dec_stable", 128'(enc_dec), 128'(modelMode));
      if (readData) check("readData_single_cycle", 128'(prevRead), 128'(0));
      prevRead = readData;
      if (m_valid && m_ready) begin
        if (expQ.size() == 0) begin
          check("unexpected_output", 128'(1), 128'(0));
        end else begin
          logic [48:0] e;
          e = expQ.pop_front();
          check("m_data", 128'(m_data), 128'(e[47:0]));
          check("m_enc_dec", 128'(m_enc_dec), 128'(e[48]));
        end
        outLog.push_back({m_enc_dec, m_data});
        popped++;
      end
      if (k_valid && k_ready) modelKey = k_data;
      if (s_valid && s_ready) begin
        modelBlock = s_data;
        modelMode = s_enc_dec;
        accepted++;
        if (discardNext) discardNext = 0;
        else expQ.push_back({s_enc_dec, simon(modelKey, s_data, s_enc_dec)});
      end
      // Core model
      if (readData) begin
        delivered++;
        dropping = 1;
        dropWait = $urandom_range(0, 2);
      end
      loadKey = newKey;
      if (newData && ($urandom_range(0, 2) != 0)) begin
        loadData = 1'b1;
        coreRes = simon(KEY, blockIN, enc_dec);
        coreLat = $urandom_range(1, 5);
        running = !stall;
      end else begin
        loadData = 1'b0;
        if (running) begin
          if (coreLat <= 1) begin
            doneData = 1'b1;
            outData = coreRes;
            running = 0;
          end else begin
            coreLat--;
          end
        end
      end
      if (dropping) begin
        if (dropWait == 0) begin
          doneData = 1'b0;
          dropping = 0;
        end else begin
          dropWait--;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (readyMode == 2) m_ready = ($urandom_range(0, 3) != 0);
      else m_ready = (readyMode == 1);
    end
  end

  task automatic sendKey(input logic [95:0] k);
    int n;
    @(posedge clk);
    #1;
    k_data = k;
    k_valid = 1'b1;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (k_ready) break;
    end
    check("k_handshake_bound", 128'(n < 3000), 128'(1));
    @(posedge clk);
    #1;
    k_valid = 1'b0;
  endtask

  task automatic sendBlock(input logic [47:0] d, input logic mode);
    int n;
    @(posedge clk);
    #1;
    s_data = d;
    s_enc_dec = mode;
    s_valid = 1'b1;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (s_ready) break;
    end
    check("s_handshake_bound", 128'(n < 3000), 128'(1));
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    for (n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (expQ.size() == 0 && !busy && !m_valid) break;
    end
    check("drain_bound", 128'(n < 5000), 128'(1));
  endtask

  logic [47:0] pt [5];
  logic [47:0] ct [5];
  logic [95:0] vecKey;
  int base, acc0, kc, dc, n;

  initial begin
    vecKey = 96'h1a1918_121110_0a0908_020100;
    repeat (3) @(posedge clk);
    #1;
    check("rst_newData", 128'(newData), 128'(0));
    check("rst_newKey", 128'(newKey), 128'(0));
    check("rst_readData", 128'(readData), 128'(0));
    check("rst_m_valid", 128'(m_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    check("rst_enc_dec", 128'(enc_dec), 128'(1));
    check("rst_blockIN", 128'(blockIN), 128'(0));
    check("rst_KEY", 128'(KEY), 128'(0));
    check("rst_blk_count", 128'(blk_count), 128'(0));
    @(negedge clk);
    nR = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_s_ready", 128'(s_ready), 128'(1));
    check("post_rst_k_ready", 128'(k_ready), 128'(1));

    // Published SIMON48/96 vector.
    readyMode = 1;
    sendKey(vecKey);
    sendBlock(48'h72696320646e, 1'b1);
    waitDrain();
    check("vector_out_count", 128'(outLog.size()), 128'(1));
    if (outLog.size() > 0)
      check("vector_ciphertext", 128'(outLog[outLog.size()-1]), 128'({1'b1, 48'h6e06a5acf156}));
    check("vector_blk_count", 128'(blk_count), 128'(1));

    // Five blocks against a stalled consumer.
    for (int i = 0; i < 5; i++) pt[i] = {$urandom, $urandom};
    readyMode = 0;
    acc0 = accepted;
    base = outLog.size();
    fork
      begin
        for (int i = 0; i < 5; i++) sendBlock(pt[i], 1'b1);
      end
      begin
        repeat (150) @(negedge clk);
        check("backpressure_accepted", 128'(accepted - acc0), 128'(2));
        check("backpressure_s_ready", 128'(s_ready), 128'(0));
        check("backpressure_m_valid", 128'(m_valid), 128'(1));
        readyMode = 1;
      end
    join
    waitDrain();
    check("five_blk_count", 128'(blk_count), 128'(6));
    for (int i = 0; i < 5; i++) ct[i] = simon(vecKey, pt[i], 1'b1);

    // Decrypting the ciphertexts must give back the plaintexts.
    base = outLog.size();
    for (int i = 0; i < 5; i++) sendBlock(ct[i], 1'b0);
    waitDrain();
    for (int i = 0; i < 5; i++)
      check("decrypt_roundtrip", 128'(outLog[base+i]), 128'({1'b0, pt[i]}));

    // Key and block offered together: key goes first.
    kc = -1;
    dc = -1;
    fork
      sendKey({$urandom, $urandom, $urandom});
      sendBlock({$urandom, $urandom}, 1'b1);
      begin
        for (int c = 0; c < 200; c++) begin
          @(negedge clk);
          if (newKey && kc < 0) kc = c;
          if (newData && dc < 0) dc = c;
        end
      end
    join
    check("priority_newKey_seen", 128'(kc >= 0), 128'(1));
    check("priority_key_first", 128'(dc > kc), 128'(1));
    waitDrain();

    // Core never reports done.
    stall = 1;
    discardNext = 1;
    sendBlock({$urandom, $urandom}, 1'b1);
    for (n = 0; n < 100 && !newData; n++) @(negedge clk);
    for (n = 0; n < 100 && newData; n++) @(negedge clk);
    for (n = 0; n < 400 && !err; n++) begin
      @(negedge clk);
      if (n == 200) begin
        check("timeout_err_early", 128'(err), 128'(0));
        check("timeout_busy_early", 128'(busy), 128'(1));
      end
    end
    check("timeout_err", 128'(err), 128'(1));
    check("timeout_cycles", 128'(n >= 250 && n <= 260), 128'(1));
    @(negedge clk);
    check("timeout_idle", 128'(busy), 128'(0));
    check("timeout_no_output", 128'(m_valid), 128'(0));
    repeat (10) @(negedge clk);
    check("err_sticky", 128'(err), 128'(1));

    // Reset in the middle of a run.
    sendBlock({$urandom, $urandom}, 1'b0);
    repeat (20) @(negedge clk);
    check("mid_run_busy", 128'(busy), 128'(1));
    @(posedge clk);
    #3;
    nR = 1'b0;
    #1;
    check("arst_busy", 128'(busy), 128'(0));
    check("arst_err", 128'(err), 128'(0));
    check("arst_newData", 128'(newData), 128'(0));
    check("arst_readData", 128'(readData), 128'(0));
    check("arst_m_valid", 128'(m_valid), 128'(0));
    check("arst_enc_dec", 128'(enc_dec), 128'(1));
    check("arst_KEY", 128'(KEY), 128'(0));
    check("arst_blk_count", 128'(blk_count), 128'(0));
    @(posedge clk);
    #3;
    nR = 1'b1;
    stall = 0;
    @(posedge clk);
    #1;
    check("arst_s_ready", 128'(s_ready), 128'(1));
    check("arst_k_ready", 128'(k_ready), 128'(1));

    // Block before any key uses the all-zero key.
    base = outLog.size();
    pt[0] = {$urandom, $urandom};
    sendBlock(pt[0], 1'b1);
    waitDrain();
    check("zero_key_count", 128'(outLog.size() - base), 128'(1));
    check("zero_key_blk_count", 128'(blk_count), 128'(1));

    // Random traffic.
    readyMode = 2;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) sendKey({$urandom, $urandom, $urandom});
      else sendBlock({$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end
    waitDrain();
    check("final_queue_empty", 128'(expQ.size()), 128'(0));
    check("final_err", 128'(err), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
